// File: rtl/branch_predict_resolve_if.sv
// Fetch-lookup / execute-resolve bundle shared by the branch predictor and the pipeline.
// The master side is the pipeline, the slave side is the predictor.
interface branch_predict_resolve_if #(
  parameter int DataWidth = 32
);
  logic [DataWidth-1:0] f_pc;
  logic                 f_pred_taken;

  logic                 e_valid;
  logic [2:0]           e_func3;
  logic [DataWidth-1:0] e_src1;
  logic [DataWidth-1:0] e_src2;
  logic [DataWidth-1:0] e_pc;
  logic                 e_pred_taken;
  logic                 flush;

  logic                 r_valid;
  logic                 r_taken;
  logic                 r_mispredict;
  logic                 r_illegal;
  logic [31:0]          branch_count;
  logic [31:0]          mispredict_count;

  modport master (
    output f_pc, e_valid, e_func3, e_src1, e_src2, e_pc, e_pred_taken, flush,
    input  f_pred_taken, r_valid, r_taken, r_mispredict, r_illegal,
           branch_count, mispredict_count
  );

  modport slave (
    input  f_pc, e_valid, e_func3, e_src1, e_src2, e_pc, e_pred_taken, flush,
    output f_pred_taken, r_valid, r_taken, r_mispredict, r_illegal,
           branch_count, mispredict_count
  );
endinterface

// File: rtl/branch_predict_resolve.sv
// Bimodal branch predictor (2-bit saturating counters) with execute-stage branch
// resolution, registered result flags and saturating performance counters.
module branch_predict_resolve #(
  parameter int DataWidth  = 32,
  parameter int BhtEntries = 64,
  parameter int IdxLsb     = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  branch_predict_resolve_if.slave bp
);
  localparam int          IdxW   = $clog2(BhtEntries);
  localparam logic [31:0] CntMax = 32'hFFFF_FFFF;

  typedef struct packed {
    logic valid;
    logic taken;
    logic mispredict;
    logic illegal;
  } res_t;

  logic [1:0]      bht_q [BhtEntries];
  logic [IdxW-1:0] f_idx;
  logic [IdxW-1:0] e_idx;
  logic            accept;
  logic            legal;
  logic            cond;
  logic            upd;
  logic [1:0]      ctr_cur;
  logic [1:0]      ctr_nxt;
  res_t            res_d;
  res_t            res_q;
  logic [31:0]     bc_q;
  logic [31:0]     mc_q;
  logic            unused_pc_bits;

  assign f_idx = bp.f_pc[IdxLsb +: IdxW];
  assign e_idx = bp.e_pc[IdxLsb +: IdxW];
  assign unused_pc_bits = ^{bp.f_pc, bp.e_pc};

  // Lookup reads the table as it stands before this edge's update (no bypass).
  assign bp.f_pred_taken = bht_q[f_idx][1];

  always_comb begin
    cond  = 1'b0;
    legal = 1'b1;
    unique case (bp.e_func3)
      3'b000:  cond = (bp.e_src1 == bp.e_src2);
      3'b001:  cond = (bp.e_src1 != bp.e_src2);
      3'b100:  cond = ($signed(bp.e_src1) <  $signed(bp.e_src2));
      3'b101:  cond = ($signed(bp.e_src1) >= $signed(bp.e_src2));
      3'b110:  cond = (bp.e_src1 <  bp.e_src2);
      3'b111:  cond = (bp.e_src1 >= bp.e_src2);
      default: legal = 1'b0;
    endcase
  end

  assign accept = bp.e_valid & ~bp.flush;
  assign upd    = accept & legal;

  always_comb begin
    res_d = '0;
    if (accept) begin
      res_d.valid      = 1'b1;
      res_d.illegal    = ~legal;
      res_d.taken      = legal & cond;
      res_d.mispredict = legal & (cond ^ bp.e_pred_taken);
    end
  end

  assign ctr_cur = bht_q[e_idx];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (cond) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < BhtEntries; i++) bht_q[i] <= 2'b01;
      res_q <= '0;
      bc_q  <= '0;
      mc_q  <= '0;
    end else begin
      res_q <= res_d;
      if (upd) begin
        bht_q[e_idx] <= ctr_nxt;
        if (bc_q != CntMax) bc_q <= bc_q + 32'd1;
        if (res_d.mispredict && (mc_q != CntMax)) mc_q <= mc_q + 32'd1;
      end
    end
  end

  assign bp.r_valid          = res_q.valid;
  assign bp.r_taken          = res_q.taken;
  assign bp.r_mispredict     = res_q.mispredict;
  assign bp.r_illegal        = res_q.illegal;
  assign bp.branch_count     = bc_q;
  assign bp.mispredict_count = mc_q;
endmodule

// File: doc/branch_predict_resolve.md
BRANCH_PREDICT_RESOLVE -- requirements
Module: branch_predict_resolve

Interface
REQ-001 SHALL provide parameter DataWidth, default 32, operand and PC width.
REQ-002 SHALL provide parameter BhtEntries, default 64, number of 2-bit history counters; power of two, at least 2.
REQ-003 SHALL provide parameter IdxLsb, default 2, lowest PC bit used to form the table index.
REQ-004 SHALL provide port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL provide port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL provide port f_pc, input, DataWidth, fetch-stage PC for lookup.
REQ-007 SHALL provide port f_pred_taken, output, 1, prediction for f_pc.
REQ-008 SHALL provide port e_valid, input, 1, a branch is presented for resolution this cycle.
REQ-009 SHALL provide port e_func3, input, 3, branch condition code.
REQ-010 SHALL provide ports e_src1 and e_src2, input, DataWidth each, comparison operands.
REQ-011 SHALL provide port e_pc, input, DataWidth, PC of the resolving branch.
REQ-012 SHALL provide port e_pred_taken, input, 1, prediction carried down the pipe for this branch.
REQ-013 SHALL provide port flush, input, 1, kill the branch in execute this cycle.
REQ-014 SHALL provide ports r_valid, r_taken, r_mispredict and r_illegal, output, 1 each, registered resolution results.
REQ-015 SHALL provide ports branch_count and mispredict_count, output, 32 each, performance counters.

Function
REQ-016 SHALL compute idx as PC bits [IdxLsb +: log2(BhtEntries)] for both f_pc and e_pc.
REQ-017 SHALL drive f_pred_taken combinationally as bit 1 of counter[idx(f_pc)], with zero-cycle latency.
REQ-018 SHALL evaluate conditions: 000 BEQ equal; 001 BNE not equal; 100 BLT signed less; 101 BGE signed greater-or-equal; 110 BLTU unsigned less; 111 BGEU unsigned greater-or-equal.
REQ-019 SHALL treat func3 010 or 011 as illegal: result not taken, r_illegal=1, no counter update, no statistic change.
REQ-020 SHALL define an accepted branch as e_valid=1 and flush=0.
REQ-021 SHALL, one cycle after an accepted branch, assert r_valid=1, with r_taken the condition result and r_mispredict = r_taken XOR e_pred_taken (0 when illegal).
REQ-022 SHALL deassert r_valid, r_taken, r_mispredict and r_illegal in the cycle after any non-accepted cycle.
REQ-023 SHALL, on an accepted legal branch, update counter[idx(e_pc)] at the same edge: taken increments, saturating at 11; not-taken decrements, saturating at 00.
REQ-024 SHALL NOT bypass: when idx(f_pc)==idx(e_pc) in the same cycle, f_pred_taken reflects the pre-update value.
REQ-025 SHALL increment branch_count on each accepted legal branch, and mispredict_count on each accepted legal mispredict, both at the same edge as REQ-023.
REQ-026 SHALL saturate both counters at 32'hFFFF_FFFF; no wrap-around.
REQ-027 SHALL give flush priority over e_valid: no update, no count, and r_valid=0 next cycle.
REQ-028 SHALL accept back-to-back branches every cycle with no bubbles.

Reset
REQ-029 SHALL, while reset=1 and independent of clk, set every counter to 01 (weakly not-taken), all r_* outputs to 0, and both statistics to 0.
REQ-030 SHALL discard a branch in execute when reset is asserted mid-operation, with no counter update and r_valid=0 after release.

Verification
REQ-031 Reset, then f_pc=0x100 -> f_pred_taken=0. Accept BEQ at e_pc=0x100 with 5,5 and e_pred_taken=0 -> next cycle r_valid=1, r_taken=1, r_mispredict=1; mispredict_count=1; f_pred_taken(0x100)=1.
REQ-032 Signed/unsigned split: src1=0xFFFFFFFF, src2=1. BLT -> taken. BLTU -> not taken. BGE -> not taken. BGEU -> taken.
REQ-033 Saturation: four taken branches at e_pc=0x40 -> counter=11. A fifth taken branch -> stays 11. One not-taken -> 10, f_pred_taken still 1.
REQ-034 Same-index lookup and update in one cycle: f_pc=e_pc=0x80, counter=01, taken branch -> f_pred_taken=0 that cycle and 1 the next. Aliasing check: 0x80 and 0x80+4*BhtEntries share one entry.
REQ-035 flush=1 with e_valid=1 -> r_valid=0, counters and statistics unchanged. func3=010 -> r_valid=1, r_illegal=1, r_taken=0, no update.
REQ-036 Assert reset asynchronously between edges -> all outputs 0 immediately. Force branch_count to 0xFFFFFFFE, then two accepted branches -> 0xFFFFFFFF held.
